mem_access_unit: RTL and testbench

Parametrised successor to the pipeline's memory stage. Accepts one load or store per transaction from EX/MEM, then aligns the address. For stores it shifts the data into the correct lanes and generates the byte mask. It runs a request/response handshake with the data cache, holding the pipeline stalled until the cache responds. For loads it extracts, sign- or zero-extends and registers the result for writeback.

---
 rtl/mem_access_unit.sv | 113 +++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage with lane alignment, byte masks, cache handshake and load extension.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses trap instead of being truncated.
module mem_access_unit #(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32,
    localparam int MASK_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   store_data,
    input  logic [4:0]        rd_in,
    input  logic              flush,
    output logic              stall,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [MASK_W-1:0] dmem_wmask,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_resp,
    output logic              wb_valid,
    output logic [XLEN-1:0]   wb_data,
    output logic [4:0]        wb_rd,
    output logic              misalign
);
    localparam int OFF_W = $clog2(MASK_W);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] sz, sz_q;
    logic [OFF_W-1:0] off_raw, off, off_q, sz_low;
    logic bad, accept, uns_q, ld_q, killed;
    logic [4:0] rd_q;
    logic [XLEN-1:0] ld_sh, ld_lm, ld_val;
    function automatic logic [XLEN-1:0] lane_mask(input logic [1:0] s);
        return ~({XLEN{1'b1}} << (7'd8 << s));
    endfunction
    function automatic logic [MASK_W-1:0] byte_mask(input logic [1:0] s);
        return ~({MASK_W{1'b1}} << (4'd1 << s));
    endfunction
    // a doubleword request on a 32-bit datapath degrades to a word
    assign sz = (XLEN == 32 && funct3[1:0] == 2'b11) ? 2'b10 : funct3[1:0];
    assign sz_low = OFF_W'((4'd1 << sz) - 4'd1);
    assign off_raw = addr[OFF_W-1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    assign off = off_raw;
    assign bad = |(off_raw & sz_low);
    assign misalign = rst & (state == IDLE) & valid_in & (is_load | is_store) & ~flush & bad;
`else
    assign off = off_raw & ~sz_low;
    assign bad = 1'b0;
    assign misalign = 1'b0;
`endif
    assign accept = rst & (state == IDLE) & valid_in & (is_load | is_store) & ~flush & ~bad;
    assign ld_sh = dmem_rdata >> {off_q, 3'b000};
    assign ld_lm = lane_mask(sz_q);
    // the sign bit is the topmost bit kept by the lane mask
    assign ld_val = (ld_sh & ld_lm) | ((~uns_q & |(ld_sh & ld_lm & ~(ld_lm >> 1))) ? ~ld_lm : '0);
    always_comb begin
        state_nx = (state == IDLE) ? (accept ? BUSY : IDLE) :
                   (state == BUSY) ? (dmem_resp ? DONE : BUSY) : IDLE;
        stall = accept | (state == BUSY);
        wb_valid = (state == DONE) & ld_q & ~killed;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dmem_read <= 1'b0;
            dmem_write <= 1'b0;
            dmem_addr <= '0;
            dmem_wdata <= '0;
            dmem_wmask <= '0;
            wb_data <= '0;
            wb_rd <= '0;
            off_q <= '0;
            sz_q <= '0;
            uns_q <= 1'b0;
            ld_q <= 1'b0;
            rd_q <= '0;
            killed <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dmem_addr <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                dmem_read <= is_load;
                dmem_write <= is_store & ~is_load;
                dmem_wdata <= (store_data & lane_mask(sz)) << {off, 3'b000};
                dmem_wmask <= byte_mask(sz) << off;
                off_q <= off;
                sz_q <= sz;
                uns_q <= funct3[2];
                ld_q <= is_load;
                rd_q <= rd_in;
                killed <= 1'b0;
            end
            if (state == BUSY) begin
                if (flush) killed <= 1'b1;
                if (dmem_resp) begin
                    dmem_read <= 1'b0;
                    dmem_write <= 1'b0;
                    if (ld_q & ~(killed | flush)) begin
                        wb_data <= ld_val;
                        wb_rd <= rd_q;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table vectors, corner sequences and random traffic on 32- and 64-bit instances.
module tb_mem_access_unit;
    logic clk, rst, sel, v32, v64, is_load, is_store, flush, resp;
    logic [2:0] funct3;
    logic [31:0] addr;
    logic [63:0] store_data, rdata;
    logic [4:0] rd_in;
    logic st32, rq32, wr32, wv32, ms32, st64, rq64, wr64, wv64, ms64;
    logic [31:0] ad32, ad64, wd32, wb32;
    logic [63:0] wd64, wb64;
    logic [3:0] wm32;
    logic [7:0] wm64;
    logic [4:0] rd32, rd64;
    logic stall, dmem_read, dmem_write, wb_valid, misalign;
    logic [31:0] dmem_addr;
    logic [63:0] dmem_wdata, wb_data;
    logic [7:0] dmem_wmask;
    logic [4:0] wb_rd;
    logic [63:0] last_wb [2];
    logic [4:0] last_rd [2];
    int n_cmp = 0, n_err = 0;

    mem_access_unit #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst), .valid_in(v32), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data[31:0]), .rd_in(rd_in),
        .flush(flush), .stall(st32), .dmem_read(rq32), .dmem_write(wr32), .dmem_addr(ad32),
        .dmem_wdata(wd32), .dmem_wmask(wm32), .dmem_rdata(rdata[31:0]), .dmem_resp(resp & ~sel),
        .wb_valid(wv32), .wb_data(wb32), .wb_rd(rd32), .misalign(ms32));
    mem_access_unit #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst), .valid_in(v64), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .rd_in(rd_in),
        .flush(flush), .stall(st64), .dmem_read(rq64), .dmem_write(wr64), .dmem_addr(ad64),
        .dmem_wdata(wd64), .dmem_wmask(wm64), .dmem_rdata(rdata), .dmem_resp(resp & sel),
        .wb_valid(wv64), .wb_data(wb64), .wb_rd(rd64), .misalign(ms64));

    assign stall = sel ? st64 : st32;
    assign dmem_read = sel ? rq64 : rq32;
    assign dmem_write = sel ? wr64 : wr32;
    assign dmem_addr = sel ? ad64 : ad32;
    assign dmem_wdata = sel ? wd64 : {32'h0, wd32};
    assign dmem_wmask = sel ? wm64 : {4'h0, wm32};
    assign wb_valid = sel ? wv64 : wv32;
    assign wb_data = sel ? wb64 : {32'h0, wb32};
    assign wb_rd = sel ? rd64 : rd32;
    assign misalign = sel ? ms64 : ms32;

    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic s, ld;
        logic [2:0] f3;
        logic [31:0] a;
        logic [63:0] d, rdat;
        logic [4:0] rd;
        int k, fl;
        logic [31:0] e_addr;
        logic [7:0] e_mask;
        logic [63:0] e_wdata, e_wb;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // byte-lane reference: lanes off..off+size-1 of a W-byte bus
    function automatic void model(input logic s, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [63:0] d, input logic [63:0] rdat,
                                  output logic [31:0] e_addr, output logic [7:0] e_mask,
                                  output logic [63:0] e_wdata, output logic [63:0] e_wb,
                                  output logic e_mis);
        int w, size, off;
        w = s ? 8 : 4;
        size = 1 << f3[1:0];
        if (size > w) size = w;
        off = int'(a % w);
        e_mis = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        e_mis = (off % size) != 0;
`else
        off = off - off % size;
`endif
        e_addr = a - a % w;
        e_mask = 0;
        e_wdata = 0;
        e_wb = 0;
        for (int i = 0; i < size; i++) begin
            e_mask[off + i] = 1'b1;
            e_wdata[8 * (off + i) +: 8] = d[8 * i +: 8];
            e_wb[8 * i +: 8] = rdat[8 * (off + i) +: 8];
        end
        if (!f3[2] && e_wb[8 * size - 1])
            for (int i = 8 * size; i < 8 * w; i++) e_wb[i] = 1'b1;
    endfunction

    task automatic run(input logic s, input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] d, input logic [63:0] rdat, input logic [4:0] rd,
                       input int k, input int fl, input logic [31:0] e_addr, input logic [7:0] e_mask,
                       input logic [63:0] e_wdata, input logic [63:0] e_wb, input logic e_mis);
        logic kill;
        @(negedge clk);
        sel = s; is_load = ld; is_store = ~ld; funct3 = f3; addr = a;
        store_data = d; rdata = rdat; rd_in = rd;
        if (s) v64 = 1; else v32 = 1;
        #1;
        if (e_mis) begin
            chk("trap_stall", stall, 0);
            chk("trap_pulse", misalign, 1);
            @(negedge clk);
            v32 = 0; v64 = 0; is_load = 0; is_store = 0;
            #1;
            chk("trap_noreq", {dmem_read, dmem_write}, 0);
            chk("trap_once", misalign, 0);
            return;
        end
        chk("accept_stall", stall, 1);
        chk("accept_nomis", misalign, 0);
        @(negedge clk);
        v32 = 0; v64 = 0; is_load = 0; is_store = 0;
        kill = 0;
        for (int j = 1; j <= k; j++) begin
            if (j > 1) @(negedge clk);
            resp = (j == k);
            flush = (j == fl);
            if (j == fl) kill = 1;
            #1;
            chk("busy_stall", stall, 1);
            chk("busy_req", {dmem_read, dmem_write}, {ld, ~ld});
            chk("busy_nowb", wb_valid, 0);
            if (j == 1) begin
                chk("req_addr", dmem_addr, e_addr);
                chk("req_mask", dmem_wmask, e_mask);
                if (!ld) chk("req_wdata", dmem_wdata, e_wdata);
            end
        end
        @(negedge clk);
        resp = 0; flush = 0;
        #1;
        chk("done_stall", stall, 0);
        chk("done_reqdrop", {dmem_read, dmem_write}, 0);
        chk("done_wbvalid", wb_valid, ld & ~kill);
        if (ld & ~kill) begin
            last_wb[s] = e_wb;
            last_rd[s] = rd;
        end
        chk("done_wbdata", wb_data, last_wb[s]);
        chk("done_wbrd", wb_rd, last_rd[s]);
        @(negedge clk);
        #1;
        chk("pulse_end", wb_valid, 0);
        chk("hold_wbdata", wb_data, last_wb[s]);
    endtask

    initial begin
        logic [31:0] ea;
        logic [7:0] em;
        logic [63:0] ew, eb;
        logic mis, ld;
        logic [2:0] f3;
        int k, fl;
        tbl[0]  = '{0, 0, 3'b010, 32'h1004, 64'hDEADBEEF, 64'h0, 5'd1, 3, 0, 32'h1004, 8'h0F, 64'hDEADBEEF, 64'h0};
        tbl[1]  = '{0, 1, 3'b000, 32'h2003, 64'h0, 64'h80FF0000, 5'd5, 1, 0, 32'h2000, 8'h08, 64'h0, 64'hFFFFFF80};
        tbl[2]  = '{0, 1, 3'b100, 32'h2003, 64'h0, 64'h80FF0000, 5'd6, 1, 0, 32'h2000, 8'h08, 64'h0, 64'h80};
        tbl[3]  = '{0, 0, 3'b001, 32'h3002, 64'h0000ABCD, 64'h0, 5'd2, 2, 0, 32'h3000, 8'h0C, 64'hABCD0000, 64'h0};
        tbl[4]  = '{0, 1, 3'b101, 32'h3002, 64'h0, 64'hABCD1234, 5'd7, 1, 0, 32'h3000, 8'h0C, 64'h0, 64'h0000ABCD};
        tbl[5]  = '{0, 1, 3'b010, 32'h0100, 64'h0, 64'h12345678, 5'd9, 2, 1, 32'h0100, 8'h0F, 64'h0, 64'h0};
        tbl[6]  = '{1, 1, 3'b011, 32'h0040, 64'h0, 64'h8000000000000001, 5'd10, 1, 0, 32'h40, 8'hFF, 64'h0, 64'h8000000000000001};
        tbl[7]  = '{1, 1, 3'b010, 32'h0044, 64'h0, 64'h8000000011112222, 5'd11, 1, 0, 32'h40, 8'hF0, 64'h0, 64'hFFFFFFFF80000000};
        tbl[8]  = '{1, 0, 3'b000, 32'h0047, 64'h123456789ABCDEAB, 64'h0, 5'd12, 4, 0, 32'h40, 8'h80, 64'hAB00000000000000, 64'h0};
        tbl[9]  = '{0, 1, 3'b011, 32'h0008, 64'h0, 64'h80000000, 5'd13, 1, 0, 32'h8, 8'h0F, 64'h0, 64'h80000000};
        tbl[10] = '{1, 1, 3'b001, 32'h0042, 64'h0, 64'h0000000080010000, 5'd14, 1, 0, 32'h40, 8'h0C, 64'h0, 64'hFFFFFFFFFFFF8001};
        tbl[11] = '{1, 1, 3'b000, 32'h0041, 64'h0, 64'hFF00, 5'd15, 2, 2, 32'h40, 8'h02, 64'h0, 64'h0};
        tbl[12] = '{1, 0, 3'b011, 32'h0048, 64'h0123456789ABCDEF, 64'h0, 5'd16, 2, 1, 32'h48, 8'hFF, 64'h0123456789ABCDEF, 64'h0};
        rst = 0; sel = 0; v32 = 1; v64 = 1; is_load = 1; is_store = 0; flush = 0; resp = 0;
        funct3 = 0; addr = 0; store_data = 0; rdata = 0; rd_in = 0;
        last_wb[0] = 0; last_wb[1] = 0; last_rd[0] = 0; last_rd[1] = 0;
        @(negedge clk);
        #1;
        chk("rst_stall", {st32, st64}, 0);
        chk("rst_req", {rq32, wr32, rq64, wr64}, 0);
        chk("rst_addr", {ad32, ad64}, 0);
        chk("rst_wmask", {wm32, wm64}, 0);
        chk("rst_wdata", wd64 | {32'h0, wd32}, 0);
        chk("rst_wb", {wv32, wv64, ms32, ms64, rd32, rd64}, 0);
        chk("rst_wbdata", wb64 | {32'h0, wb32}, 0);
        v32 = 0; v64 = 0; is_load = 0;
        @(negedge clk);
        rst = 1;
        foreach (tbl[i])
            run(tbl[i].s, tbl[i].ld, tbl[i].f3, tbl[i].a, tbl[i].d, tbl[i].rdat, tbl[i].rd,
                tbl[i].k, tbl[i].fl, tbl[i].e_addr, tbl[i].e_mask, tbl[i].e_wdata, tbl[i].e_wb, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        run(0, 1, 3'b010, 32'h1002, 64'h0, 64'hCAFEF00D, 5'd3, 1, 0, 32'h0, 8'h0, 64'h0, 64'h0, 1'b1);
`else
        run(0, 1, 3'b010, 32'h1002, 64'h0, 64'hCAFEF00D, 5'd3, 1, 0, 32'h1000, 8'h0F, 64'h0, 64'hCAFEF00D, 1'b0);
`endif
        @(negedge clk);
        sel = 0; v32 = 1; is_load = 0; is_store = 0;
        #1;
        chk("nonmem_stall", stall, 0);
        @(negedge clk);
        is_load = 1; flush = 1;
        #1;
        chk("flush_idle_stall", stall, 0);
        @(negedge clk);
        v32 = 0; is_load = 0; flush = 0; resp = 1;
        #1;
        chk("flush_idle_noreq", {dmem_read, dmem_write}, 0);
        @(negedge clk);
        resp = 0;
        #1;
        chk("idle_resp_ignored", {stall, dmem_read, wb_valid}, 0);
        @(negedge clk);
        v32 = 1; is_load = 1; funct3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        v32 = 0; is_load = 0;
        #1;
        chk("midbusy_req", dmem_read, 1);
        #2 rst = 0;
        #1;
        chk("midbusy_rst_req", dmem_read, 0);
        chk("midbusy_rst_stall", stall, 0);
        chk("midbusy_rst_wb", wb_data, 0);
        last_wb[0] = 0; last_wb[1] = 0; last_rd[0] = 0; last_rd[1] = 0;
        @(negedge clk);
        rst = 1;
        for (int n = 0; n < 80; n++) begin
            sel = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            k = $urandom_range(1, 4);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, k) : 0;
            addr = $urandom & 32'hFFFF;
            store_data = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            model(sel, f3, addr, store_data, rdata, ea, em, ew, eb, mis);
            run(sel, ld, f3, addr, store_data, rdata, 5'($urandom), k, fl, ea, em, ew, eb, mis);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
